// File: rtl/card_pkg.sv
// card_pkg: shared definitions for the Baccarat hand display.
//   - SEG_* : 7-segment glyphs, bit6..bit0 (segments a..g)
//   - card_code_e : 4-bit dealt-card code (1=A .. 13=K; 0/14/15 illegal)
//   - blink_state_e : state of the newest-card blink FSM (CARD_BLINK_EN builds)
//   - card_is_legal(code) : 1 for codes 1..13
//   - card_points(code) : Baccarat value 0..9 of a code (0 for illegal codes)
package card_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_ACE   = 7'b1110111;
  localparam logic [6:0] SEG_TWO   = 7'b1101101;
  localparam logic [6:0] SEG_THREE = 7'b1111001;
  localparam logic [6:0] SEG_FOUR  = 7'b0110011;
  localparam logic [6:0] SEG_FIVE  = 7'b1011011;
  localparam logic [6:0] SEG_SIX   = 7'b1011111;
  localparam logic [6:0] SEG_SEVEN = 7'b1110000;
  localparam logic [6:0] SEG_EIGHT = 7'b1111111;
  localparam logic [6:0] SEG_NINE  = 7'b1111011;
  localparam logic [6:0] SEG_TEN   = 7'b1111110;
  localparam logic [6:0] SEG_JACK  = 7'b0111100;
  localparam logic [6:0] SEG_QUEEN = 7'b1110011;
  localparam logic [6:0] SEG_KING  = 7'b0110111;

  typedef enum logic [3:0] {
    CARD_NONE  = 4'd0,
    CARD_ACE   = 4'd1,
    CARD_TWO   = 4'd2,
    CARD_THREE = 4'd3,
    CARD_FOUR  = 4'd4,
    CARD_FIVE  = 4'd5,
    CARD_SIX   = 4'd6,
    CARD_SEVEN = 4'd7,
    CARD_EIGHT = 4'd8,
    CARD_NINE  = 4'd9,
    CARD_TEN   = 4'd10,
    CARD_JACK  = 4'd11,
    CARD_QUEEN = 4'd12,
    CARD_KING  = 4'd13
  } card_code_e;

  typedef enum logic {
    BLINK_IDLE = 1'b0,
    BLINK_RUN  = 1'b1
  } blink_state_e;

  function automatic logic card_is_legal(input logic [3:0] code);
    return (code >= 4'(CARD_ACE)) && (code <= 4'(CARD_KING));
  endfunction

  // Ace counts 1, pips count face value, ten and court cards count 0.
  function automatic logic [3:0] card_points(input logic [3:0] code);
    logic [3:0] pts;
    if ((code >= 4'(CARD_ACE)) && (code <= 4'(CARD_NINE))) pts = code;
    else                                                    pts = 4'd0;
    return pts;
  endfunction

endpackage

// File: rtl/card_seg_decode.sv
// card_seg_decode: combinational card code -> 7-segment glyph lookup.
//   code in  [3:0] card code (1=A .. 13=K)
//   seg  out [6:0] glyph, bit6..bit0; illegal codes (0, 14, 15) give blank
module card_seg_decode
  import card_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd1:    seg = SEG_ACE;
      4'd2:    seg = SEG_TWO;
      4'd3:    seg = SEG_THREE;
      4'd4:    seg = SEG_FOUR;
      4'd5:    seg = SEG_FIVE;
      4'd6:    seg = SEG_SIX;
      4'd7:    seg = SEG_SEVEN;
      4'd8:    seg = SEG_EIGHT;
      4'd9:    seg = SEG_NINE;
      4'd10:   seg = SEG_TEN;
      4'd11:   seg = SEG_JACK;
      4'd12:   seg = SEG_QUEEN;
      4'd13:   seg = SEG_KING;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/card_hand_display.sv
// card_hand_display: registered multi-slot display for one Baccarat hand.
// Cards arrive over a valid/ready handshake and fill slots in dealing order;
// each slot drives one 7-segment digit and a running score (sum mod 10) is kept.
//
// Handshake: a card is consumed on a rising edge where deal_valid && deal_ready.
// deal_ready = !full && !clear (combinational); the producer holds deal_card
// stable while deal_valid is high and not yet accepted.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   deal_valid     card offered on deal_card
//   deal_card[3:0] card code, 1=A .. 13=K (0, 14, 15 are illegal)
//   deal_ready     card can be accepted this cycle
//   clear          start a new hand (priority over a simultaneous deal)
//   hex            7 bits per slot, slot i at [7i+6:7i], slot 0 = first card
//   score[3:0]     hand score 0..9
//   count[2:0]     number of filled slots
//   full           count == NUM_SLOTS
//   bad_card       one-cycle pulse after an illegal code was consumed
//
// Optional feature, macro CARD_BLINK_EN: the newest card's digit blinks
// (blank first) for four half-periods of BLINK_HALF cycles, then goes steady.
module card_hand_display
  import card_pkg::*;
#(
  parameter int NUM_SLOTS  = 3,
  parameter int BLINK_HALF = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   deal_valid,
  input  logic [3:0]             deal_card,
  output logic                   deal_ready,
  input  logic                   clear,
  output logic [7*NUM_SLOTS-1:0] hex,
  output logic [3:0]             score,
  output logic [2:0]             count,
  output logic                   full,
  output logic                   bad_card
);

  logic [3:0]             slot_q  [NUM_SLOTS];
  logic [3:0]             slot_d  [NUM_SLOTS];
  logic [6:0]             glyph_d [NUM_SLOTS];
  logic [7*NUM_SLOTS-1:0] hex_q, hex_d;
  logic [3:0]             score_q, score_d;
  logic [2:0]             count_q, count_d;
  logic                   full_q, full_d;
  logic                   bad_q, bad_d;
  logic [4:0]             sum5;
  logic                   accept;
  logic                   accept_legal;

  assign deal_ready   = !full_q && !clear;
  assign accept       = deal_valid && deal_ready;
  assign accept_legal = accept && card_is_legal(deal_card);

  // Slot, count and score next state. Glyphs are decoded from the next-state
  // slot codes so the digit is registered alongside count and score.
  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    score_d = score_q;
    bad_d   = 1'b0;
    sum5    = {1'b0, score_q} + {1'b0, card_points(deal_card)};
    if (clear) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = 4'd0;
      count_d = 3'd0;
      score_d = 4'd0;
    end else if (accept_legal) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (count_q == 3'(i)) slot_d[i] = deal_card;
      end
      count_d = count_q + 3'd1;
      // Both operands are <= 9, so one conditional subtract is a full mod 10.
      score_d = (sum5 >= 5'd10) ? 4'(sum5 - 5'd10) : sum5[3:0];
    end else if (accept) begin
      bad_d = 1'b1;
    end
    full_d = (count_d == 3'(NUM_SLOTS));
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    card_seg_decode u_dec (
      .code (slot_d[g]),
      .seg  (glyph_d[g])
    );
  end

`ifdef CARD_BLINK_EN
  localparam int PH_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  blink_state_e    blink_state_q, blink_state_d;
  logic [PH_W-1:0] phase_q, phase_d;     // cycle within the current half-period
  logic [1:0]      half_q, half_d;       // half-period index 0..3, even = blank
  logic [2:0]      blink_slot_q, blink_slot_d;

  always_comb begin
    blink_state_d = blink_state_q;
    phase_d       = phase_q;
    half_d        = half_q;
    blink_slot_d  = blink_slot_q;
    if (clear) begin
      blink_state_d = BLINK_IDLE;
      phase_d       = '0;
      half_d        = 2'd0;
    end else if (accept_legal) begin
      // A new card restarts the blink; the previous slot is steady at once.
      blink_state_d = BLINK_RUN;
      phase_d       = '0;
      half_d        = 2'd0;
      blink_slot_d  = count_q;
    end else if (blink_state_q == BLINK_RUN) begin
      if (phase_q == PH_W'(BLINK_HALF - 1)) begin
        phase_d = '0;
        if (half_q == 2'd3) blink_state_d = BLINK_IDLE;
        else                half_d = half_q + 2'd1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hex_d[7*i +: 7] = glyph_d[i];
      if ((blink_state_d == BLINK_RUN) && (blink_slot_d == 3'(i)) && !half_d[0])
        hex_d[7*i +: 7] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_state_q <= BLINK_IDLE;
      phase_q       <= '0;
      half_q        <= 2'd0;
      blink_slot_q  <= 3'd0;
    end else begin
      blink_state_q <= blink_state_d;
      phase_q       <= phase_d;
      half_q        <= half_d;
      blink_slot_q  <= blink_slot_d;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) hex_d[7*i +: 7] = glyph_d[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= 4'd0;
      hex_q   <= '0;
      score_q <= 4'd0;
      count_q <= 3'd0;
      full_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      hex_q   <= hex_d;
      score_q <= score_d;
      count_q <= count_d;
      full_q  <= full_d;
      bad_q   <= bad_d;
    end
  end

  assign hex      = hex_q;
  assign score    = score_q;
  assign count    = count_q;
  assign full     = full_q;
  assign bad_card = bad_q;

endmodule

// File: tb/tb_card_hand_display.sv
// Directed bench for card_hand_display with NUM_SLOTS=3, BLINK_HALF=4.
// Expected values are hand-computed glyphs and scores.
module tb_card_hand_display;

  localparam int N  = 3;
  localparam int BH = 4;
  localparam int W  = 7 * N;

  localparam logic [6:0] G_BLANK = 7'b0000000;
  localparam logic [6:0] G_A     = 7'b1110111;
  localparam logic [6:0] G_5     = 7'b1011011;
  localparam logic [6:0] G_6     = 7'b1011111;
  localparam logic [6:0] G_7     = 7'b1110000;
  localparam logic [6:0] G_8     = 7'b1111111;
  localparam logic [6:0] G_9     = 7'b1111011;
  localparam logic [6:0] G_10    = 7'b1111110;
  localparam logic [6:0] G_Q     = 7'b1110011;
  localparam logic [6:0] G_K     = 7'b0110111;

  logic         clk = 1'b0;
  logic         reset;
  logic         deal_valid;
  logic [3:0]   deal_card;
  logic         deal_ready;
  logic         clear;
  logic [W-1:0] hex;
  logic [3:0]   score;
  logic [2:0]   count;
  logic         full;
  logic         bad_card;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  card_hand_display #(.NUM_SLOTS(N), .BLINK_HALF(BH)) dut (
    .clk        (clk),
    .reset      (reset),
    .deal_valid (deal_valid),
    .deal_card  (deal_card),
    .deal_ready (deal_ready),
    .clear      (clear),
    .hex        (hex),
    .score      (score),
    .count      (count),
    .full       (full),
    .bad_card   (bad_card)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge, outputs are
  // checked at that same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic deal_one(input logic [3:0] c);
    deal_valid = 1'b1;
    deal_card  = c;
    tick();
    deal_valid = 1'b0;
    deal_card  = 4'd0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    check("ready_low_in_clear", 32'(deal_ready), 32'd0);
    tick();
    clear = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hex"},   32'(hex),      32'd0);
    check({tag, "_score"}, 32'(score),    32'd0);
    check({tag, "_count"}, 32'(count),    32'd0);
    check({tag, "_full"},  32'(full),     32'd0);
    check({tag, "_bad"},   32'(bad_card), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    deal_valid = 1'b0;
    deal_card  = 4'd0;
    clear      = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b0;
    #1;
    check("reset_ready", 32'(deal_ready), 32'd1);

    // 8 then 7: 15 mod 10 = 5
    deal_one(4'd8);
    deal_one(4'd7);
    check("d87_hex",   32'(hex),        32'({G_BLANK, G_7, G_8}));
    check("d87_score", 32'(score),      32'd5);
    check("d87_count", 32'(count),      32'd2);
    check("d87_ready", 32'(deal_ready), 32'd1);
    check("d87_full",  32'(full),       32'd0);

    // K, Q, A back-to-back: 0+0+1 = 1, hand full
    do_clear();
    check_reset_state("clr1");
    deal_one(4'd13);
    deal_one(4'd12);
    deal_one(4'd1);
    check("kqa_hex",   32'(hex),        32'({G_A, G_Q, G_K}));
    check("kqa_score", 32'(score),      32'd1);
    check("kqa_count", 32'(count),      32'd3);
    check("kqa_full",  32'(full),       32'd1);
    check("kqa_ready", 32'(deal_ready), 32'd0);
    // 4th card offered while full must be ignored
    deal_valid = 1'b1;
    deal_card  = 4'd9;
    tick();
    tick();
    deal_valid = 1'b0;
    check("over_hex",   32'(hex),   32'({G_A, G_Q, G_K}));
    check("over_score", 32'(score), 32'd1);
    check("over_count", 32'(count), 32'd3);

    // Illegal code 14 into an empty hand
    do_clear();
    deal_one(4'd14);
    check("bad14_pulse", 32'(bad_card), 32'd1);
    check("bad14_count", 32'(count),    32'd0);
    check("bad14_hex",   32'(hex),      32'd0);
    tick();
    check("bad14_drop",  32'(bad_card), 32'd0);
    deal_one(4'd10);
    check("ten_hex",   32'(hex),      32'({G_BLANK, G_BLANK, G_10}));
    check("ten_score", 32'(score),    32'd0);
    check("ten_count", 32'(count),    32'd1);
    check("ten_bad",   32'(bad_card), 32'd0);
    deal_one(4'd0);
    check("bad0_pulse", 32'(bad_card), 32'd1);
    check("bad0_count", 32'(count),    32'd1);

    // Clear and deal in the same cycle: clear wins, card not stored
    do_clear();
    deal_one(4'd3);
    deal_one(4'd4);
    check("d34_score", 32'(score), 32'd7);
    clear      = 1'b1;
    deal_valid = 1'b1;
    deal_card  = 4'd9;
    tick();
    clear      = 1'b0;
    deal_valid = 1'b0;
    check_reset_state("clrdeal");
    tick();
    check("clrdeal_count2", 32'(count), 32'd0);

    // Newest-digit display over the 14 cycles after dealing a 5
    for (int k = 1; k <= 14; k++) begin
`ifdef CARD_BLINK_EN
      if ((k >= 1 && k <= 4) || (k >= 9 && k <= 12)) exp_q.push_back(W'(G_BLANK));
      else                                            exp_q.push_back(W'(G_5));
`else
      exp_q.push_back(W'(G_5));
`endif
    end
    deal_one(4'd5);
    for (int k = 1; k <= 14; k++) begin
      check($sformatf("blink_c%0d", k), 32'(hex), 32'(exp_q.pop_front()));
      tick();
    end
    check("five_score", 32'(score), 32'd5);

    // Second card (5+6 = 11 -> 1), then reset in the middle of its blink
    deal_one(4'd6);
    check("d56_score", 32'(score), 32'd1);
    check("d56_count", 32'(count), 32'd2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("midreset");
    tick();
    check("midreset_hold", 32'(hex), 32'd0);

    // 9 + 9 = 18 -> 8 exercises the subtract-10 path after reset
    deal_one(4'd9);
    deal_one(4'd9);
    check("d99_score", 32'(score), 32'd8);
    repeat (4 * BH + 2) tick();
    check("d99_hex", 32'(hex), 32'({G_BLANK, G_9, G_9}));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected earlier");
    $fatal(1);
  end

endmodule
